// File: rtl/bus_arbiter_if.sv
// Request/grant/strobe bundle shared by the bus masters and the arbiter.
// master: requester side; slave: arbiter side.
interface bus_arbiter_if #(
   parameter int NUM_MASTERS = 4
);
   localparam int IDW = $clog2(NUM_MASTERS);

   logic [NUM_MASTERS-1:0] request;
   logic [NUM_MASTERS-1:0] granted;
   logic [IDW-1:0]         grant_id;
   logic                   begin_transactionIN;
   logic                   end_transactionIN;
   logic                   errorIN;
   logic                   bus_idle;
   logic                   timeout;

   modport master (
      output request, begin_transactionIN, end_transactionIN, errorIN,
      input  granted, grant_id, bus_idle, timeout
   );

   modport slave (
      input  request, begin_transactionIN, end_transactionIN, errorIN,
      output granted, grant_id, bus_idle, timeout
   );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with an IDLE/GRANT/BUSY/RELEASE handshake FSM.
// Define ARB_TIMEOUT_EN to add a watchdog that force-releases a stuck grant.
module bus_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic          clock,
   input logic          reset,
   bus_arbiter_if.slave bus
);
   localparam int IDW = $clog2(NUM_MASTERS);

   if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
      $error("bus_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, GRANT, BUSY, RELEASE} state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] granted_q, granted_d;
   logic [IDW-1:0]         grant_id_q, grant_id_d;
   logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
   logic                   timeout_q, timeout_d;
   logic [IDW-1:0]         winner;
   logic [IDW-1:0]         cand;
   logic                   found;
   logic                   expired;

`ifdef ARB_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYCLES);
   logic [WDW-1:0] wd_cnt_q, wd_cnt_d;

   assign expired = (wd_cnt_q == WDW'(TIMEOUT_CYCLES - 1));

   // Cleared while idle so it starts from zero on entry to GRANT.
   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (state_q == IDLE) begin
         wd_cnt_d = '0;
      end else if (state_q == GRANT || state_q == BUSY) begin
         wd_cnt_d = wd_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wd_cnt_q <= '0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
      end
   end
`else
   assign expired = 1'b0;
`endif

   // First requester at or after rr_ptr, wrapping past the top index.
   always_comb begin
      int idx;
      winner = rr_ptr_q;
      cand   = rr_ptr_q;
      found  = 1'b0;
      idx    = 0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_MASTERS) begin
            idx = idx - NUM_MASTERS;
         end
         cand = IDW'(idx);
         if (!found && bus.request[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      granted_d  = granted_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      timeout_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d    = GRANT;
               granted_d  = NUM_MASTERS'(1) << winner;
               grant_id_d = winner;
            end
         end
         GRANT: begin
            // A completed or abandoned grant beats a watchdog expiry in the same cycle.
            if (bus.begin_transactionIN && bus.end_transactionIN) begin
               state_d = RELEASE;
            end else if (!bus.begin_transactionIN && !bus.request[grant_id_q]) begin
               state_d = RELEASE;
            end else if (expired) begin
               state_d   = RELEASE;
               timeout_d = 1'b1;
            end else if (bus.begin_transactionIN) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (bus.end_transactionIN || bus.errorIN) begin
               state_d = RELEASE;
            end else if (expired) begin
               state_d   = RELEASE;
               timeout_d = 1'b1;
            end
         end
         RELEASE: begin
            state_d  = IDLE;
            rr_ptr_d = (grant_id_q == IDW'(NUM_MASTERS - 1)) ? '0 : grant_id_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (state_d == RELEASE) begin
         granted_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         granted_q  <= '0;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         granted_q  <= granted_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
         timeout_q  <= timeout_d;
      end
   end

   assign bus.granted  = granted_q;
   assign bus.grant_id = grant_id_q;
   assign bus.bus_idle = (state_q == IDLE);
   assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: arbitration order, handshake paths, reset and watchdog.
module tb_bus_arbiter;
   logic clock;
   logic reset;
   int   n_cmp;
   int   n_err;

   bus_arbiter_if #(.NUM_MASTERS(4)) bus ();

   bus_arbiter #(
      .NUM_MASTERS   (4),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      chk("onehot0", 32'($onehot0(bus.granted)), 32'd1);
   endtask

   task automatic strobes(input logic b, input logic e, input logic r);
      bus.begin_transactionIN = b;
      bus.end_transactionIN   = e;
      bus.errorIN             = r;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      bus.request = 4'b0000;
      strobes(0, 0, 0);

      // Reset state
      tick();
      chk("rst_granted", 32'(bus.granted), 32'h0);
      chk("rst_grant_id", 32'(bus.grant_id), 32'h0);
      chk("rst_bus_idle", 32'(bus.bus_idle), 32'h1);
      chk("rst_timeout", 32'(bus.timeout), 32'h0);

      reset = 1'b0;
      tick();
      chk("idle_noreq_granted", 32'(bus.granted), 32'h0);
      chk("idle_noreq_bus_idle", 32'(bus.bus_idle), 32'h1);

      // Two requesters, master 0 first after reset, then master 2
      bus.request = 4'b0101;
      tick();
      chk("first_grant", 32'(bus.granted), 32'h1);
      chk("first_grant_id", 32'(bus.grant_id), 32'h0);
      chk("first_bus_idle", 32'(bus.bus_idle), 32'h0);
      strobes(1, 0, 0);
      tick();
      chk("busy_granted", 32'(bus.granted), 32'h1);
      strobes(0, 1, 0);
      tick();
      chk("release_granted", 32'(bus.granted), 32'h0);
      strobes(0, 0, 0);
      tick();
      chk("post_release_idle", 32'(bus.bus_idle), 32'h1);
      chk("post_release_granted", 32'(bus.granted), 32'h0);
      tick();
      chk("second_grant", 32'(bus.granted), 32'h4);
      chk("second_grant_id", 32'(bus.grant_id), 32'h2);

      // Single-cycle transaction; grant_id holds through release
      strobes(1, 1, 0);
      tick();
      chk("single_cycle_release", 32'(bus.granted), 32'h0);
      chk("grant_id_hold", 32'(bus.grant_id), 32'h2);
      strobes(0, 0, 0);
      tick();
      tick();
      chk("wrap_grant", 32'(bus.granted), 32'h1);
      chk("wrap_grant_id", 32'(bus.grant_id), 32'h0);

      // Abandoned grant on master 1 moves the pointer to 2
      strobes(1, 1, 0);
      bus.request = 4'b0010;
      tick();
      strobes(0, 0, 0);
      tick();
      tick();
      chk("m1_grant", 32'(bus.granted), 32'h2);
      bus.request = 4'b0000;
      tick();
      chk("abandon_release", 32'(bus.granted), 32'h0);
      chk("abandon_not_idle", 32'(bus.bus_idle), 32'h0);
      tick();
      bus.request = 4'b1111;
      tick();
      chk("rr_after_abandon", 32'(bus.granted), 32'h4);
      chk("rr_after_abandon_id", 32'(bus.grant_id), 32'h2);

      // Reset mid-grant, then full rotation with all masters requesting
      reset = 1'b1;
      tick();
      chk("rst_mid_granted", 32'(bus.granted), 32'h0);
      chk("rst_mid_id", 32'(bus.grant_id), 32'h0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rot_granted", 32'(bus.granted), 32'h1 << (i % 4));
         chk("rot_grant_id", 32'(bus.grant_id), 32'(i % 4));
         strobes(1, 1, 0);
         tick();
         chk("rot_turnaround", 32'(bus.granted), 32'h0);
         strobes(0, 0, 0);
         tick();
         chk("rot_idle", 32'(bus.bus_idle), 32'h1);
      end

      // BUSY ignores request changes; error ends the transaction
      bus.request = 4'b0010;
      tick();
      chk("err_grant", 32'(bus.granted), 32'h2);
      strobes(1, 0, 0);
      tick();
      strobes(0, 0, 0);
      bus.request = 4'b0000;
      tick();
      chk("busy_ignores_req", 32'(bus.granted), 32'h2);
      chk("busy_not_idle", 32'(bus.bus_idle), 32'h0);
      strobes(0, 0, 1);
      tick();
      chk("err_release", 32'(bus.granted), 32'h0);
      chk("err_timeout", 32'(bus.timeout), 32'h0);
      strobes(0, 0, 0);
      tick();

      // Strobes while idle do nothing
      strobes(1, 1, 1);
      tick();
      chk("idle_strobe_granted", 32'(bus.granted), 32'h0);
      chk("idle_strobe_bus_idle", 32'(bus.bus_idle), 32'h1);
      strobes(0, 0, 0);

      // Reset while master 3 is busy, then master 0 wins
      bus.request = 4'b1000;
      tick();
      chk("m3_grant", 32'(bus.granted), 32'h8);
      chk("m3_grant_id", 32'(bus.grant_id), 32'h3);
      strobes(1, 0, 0);
      tick();
      strobes(0, 1, 0);
      reset = 1'b1;
      tick();
      chk("rst_busy_granted", 32'(bus.granted), 32'h0);
      chk("rst_busy_bus_idle", 32'(bus.bus_idle), 32'h1);
      reset = 1'b0;
      strobes(0, 0, 0);
      bus.request = 4'b1001;
      tick();
      chk("post_rst_grant", 32'(bus.granted), 32'h1);

      // Stuck grant: watchdog release or indefinite hold
`ifdef ARB_TIMEOUT_EN
      repeat (15) tick();
      chk("wd_before_granted", 32'(bus.granted), 32'h1);
      chk("wd_before_timeout", 32'(bus.timeout), 32'h0);
      tick();
      chk("wd_release_granted", 32'(bus.granted), 32'h0);
      chk("wd_timeout_pulse", 32'(bus.timeout), 32'h1);
      tick();
      chk("wd_timeout_clear", 32'(bus.timeout), 32'h0);
      chk("wd_back_idle", 32'(bus.bus_idle), 32'h1);
`else
      repeat (120) tick();
      chk("hold_granted", 32'(bus.granted), 32'h1);
      chk("hold_timeout", 32'(bus.timeout), 32'h0);
      chk("hold_not_idle", 32'(bus.bus_idle), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
